// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around mem_arbiter.
// slave is the arbiter's view; master is the requester/memory environment's view.
interface mem_arbiter_if;
  logic [31:0] i_addr;
  logic        i_addr_valid;
  logic        i_rdata_valid;
  logic [31:0] i_rdata;

  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_wen;
  logic        d_valid;
  logic        d_rdata_valid;
  logic [31:0] d_rdata;

  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_resp_valid;
  logic [31:0] m_rdata;

  logic [1:0]  err;

  modport slave (
    input  i_addr, i_addr_valid, d_addr, d_wdata, d_wmask, d_wen, d_valid,
           m_resp_valid, m_rdata,
    output i_rdata_valid, i_rdata, d_rdata_valid, d_rdata,
           m_valid, m_addr, m_wen, m_wdata, m_wmask, err
  );

  modport master (
    output i_addr, i_addr_valid, d_addr, d_wdata, d_wmask, d_wen, d_valid,
           m_resp_valid, m_rdata,
    input  i_rdata_valid, i_rdata, d_rdata_valid, d_rdata,
           m_valid, m_addr, m_wen, m_wdata, m_wmask, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the IFU and LSU turns on one single-outstanding memory port,
// with sticky timeout / spurious-response error flags.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIfetch, StData} state_e;

  state_e          state_q, state_d;
  logic            last_data_q, last_data_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [3:0]      m_wmask_q, m_wmask_d;
  logic            m_wen_q, m_wen_d;
  logic [1:0]      err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_data_q <= 1'b1;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wmask_q   <= '0;
      m_wen_q     <= 1'b0;
      err_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wmask_q   <= m_wmask_d;
      m_wen_q     <= m_wen_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wmask_d   = m_wmask_q;
    m_wen_d     = m_wen_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Nothing is outstanding, so any response here is spurious and dropped.
        if (bus.m_resp_valid) begin
          err_d[1] = 1'b1;
        end
        if (bus.i_addr_valid && (!bus.d_valid || last_data_q)) begin
          state_d   = StIfetch;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          m_wmask_d = '0;
          m_wen_d   = 1'b0;
        end else if (bus.d_valid) begin
          state_d   = StData;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_wmask_d = bus.d_wen ? bus.d_wmask : 4'b0000;
          m_wen_d   = bus.d_wen;
        end
      end
      StIfetch, StData: begin
        if (bus.m_resp_valid) begin
          state_d     = StIdle;
          last_data_d = (state_q == StData);
          cnt_d       = '0;
        end else begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Flag only; the transaction keeps waiting for its response.
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == CntMax)) begin
            err_d[0] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.m_valid       = (state_q != StIdle);
  assign bus.m_addr        = m_addr_q;
  assign bus.m_wdata       = m_wdata_q;
  assign bus.m_wmask       = m_wmask_q;
  assign bus.m_wen         = m_wen_q;
  assign bus.i_rdata_valid = (state_q == StIfetch) && bus.m_resp_valid;
  assign bus.d_rdata_valid = (state_q == StData) && bus.m_resp_valid;
  assign bus.i_rdata       = bus.m_rdata;
  assign bus.d_rdata       = bus.m_rdata;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked against a transaction-level model
// of the round-robin arbitration, latched request fields, strobes and error flags.
module tb_mem_arbiter;
  localparam int unsigned Tmo = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: pending requests, their fields, who was served last, expected error flags.
  bit          pend_i, pend_d, last_d;
  logic [31:0] ia, da, dw;
  logic [3:0]  dm;
  logic        dwen;
  logic [1:0]  exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    bus.i_addr_valid = pend_i;
    bus.i_addr       = ia;
    bus.d_valid      = pend_d;
    bus.d_addr       = da;
    bus.d_wdata      = dw;
    bus.d_wmask      = dm;
    bus.d_wen        = dwen;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    pend_i           = 0;
    pend_d           = 0;
    last_d           = 1;
    exp_err          = 2'b00;
    drive_reqs();
    bus.m_resp_valid = 1'b0;
    bus.m_rdata      = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_strobes", 64'({bus.i_rdata_valid, bus.d_rdata_valid}), 64'(0));
    chk("rst_m_regs", 64'({bus.m_addr, bus.m_wen, bus.m_wmask}), 64'(0));
  endtask

  // Called in an idle cycle: present pending requests, follow one transaction to completion.
  task automatic txn(input int dly, input logic [31:0] rdata, input bit wiggle);
    bit          win_d;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic        exp_wen;
    drive_reqs();
    bus.m_resp_valid = 1'b0;
    #1;
    chk("idle_m_valid", 64'(bus.m_valid), 64'(0));
    chk("idle_err", 64'(bus.err), 64'(exp_err));

    win_d    = pend_d && (!pend_i || !last_d);
    exp_addr = win_d ? da : ia;
    exp_wen  = win_d ? dwen : 1'b0;
    exp_mask = (win_d && dwen) ? dm : 4'b0000;

    @(posedge clk);
    #2;
    if (wiggle) begin
      bus.i_addr  = ~ia;
      bus.d_addr  = ~da;
      bus.d_wdata = ~dw;
      bus.d_wmask = ~dm;
    end
    #1;
    chk("grant_m_valid", 64'(bus.m_valid), 64'(1));
    chk("grant_m_addr", 64'(bus.m_addr), 64'(exp_addr));
    chk("grant_m_wen", 64'(bus.m_wen), 64'(exp_wen));
    chk("grant_m_wmask", 64'(bus.m_wmask), 64'(exp_mask));
    if (win_d && dwen) chk("grant_m_wdata", 64'(bus.m_wdata), 64'(dw));

    for (int j = 0; j < dly; j++) begin
      @(posedge clk);
      #3;
      if (j + 1 >= int'(Tmo)) exp_err[0] = 1'b1;
      chk("wait_m_valid", 64'(bus.m_valid), 64'(1));
      chk("wait_m_addr", 64'(bus.m_addr), 64'(exp_addr));
      chk("wait_strobes", 64'({bus.i_rdata_valid, bus.d_rdata_valid}), 64'(0));
      chk("wait_err", 64'(bus.err), 64'(exp_err));
    end

    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = rdata;
    #1;
    chk("resp_i_strobe", 64'(bus.i_rdata_valid), 64'(!win_d));
    chk("resp_d_strobe", 64'(bus.d_rdata_valid), 64'(win_d));
    if (!win_d) chk("resp_i_rdata", 64'(bus.i_rdata), 64'(rdata));
    else if (!dwen) chk("resp_d_rdata", 64'(bus.d_rdata), 64'(rdata));

    @(posedge clk);
    #2;
    bus.m_resp_valid = 1'b0;
    if (win_d) pend_d = 0;
    else pend_i = 0;
    last_d = win_d;
    drive_reqs();
  endtask

  task automatic set_i(input logic [31:0] a);
    pend_i = 1;
    ia     = a;
  endtask

  task automatic set_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                       input logic we);
    pend_d = 1;
    da     = a;
    dw     = w;
    dm     = m;
    dwen   = we;
  endtask

  initial begin
    ia = '0; da = '0; dw = '0; dm = '0; dwen = 1'b0;
    do_reset();

    // Collision straight after reset: IFU first, then LSU, then IFU wins the next collision.
    set_i(32'h0000_1000);
    set_d(32'h0000_2001, 32'h1111_2222, 4'b1111, 1'b0);
    txn(1, 32'hA5A5_0001, 0);
    chk("alt_d_still_pending", 64'(pend_d), 64'(1));
    txn(0, 32'hA5A5_0002, 0);
    set_i(32'h0000_1004);
    set_d(32'h0000_2005, 32'h3333_4444, 4'b0001, 1'b1);
    txn(0, 32'hA5A5_0003, 0);
    txn(2, 32'hA5A5_0004, 0);

    // IFU-only fetch answered one cycle after m_valid.
    set_i(32'h8000_0000);
    txn(1, 32'h0000_0413, 0);

    // LSU store with partial byte enables.
    set_d(32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    txn(1, 32'h0, 0);

    // Requester inputs changing during a fetch grant must not leak onto m_*.
    set_i(32'h8000_0040);
    txn(2, 32'h1234_5678, 1);

    // Randomized mix; delays stay below the timeout threshold.
    for (int k = 0; k < 40; k++) begin
      if (!pend_i && ($urandom_range(1) == 1)) set_i($urandom & 32'hFFFF_FFFE);
      if (!pend_d && ($urandom_range(1) == 1))
        set_d($urandom | 32'h1, $urandom, 4'($urandom), 1'($urandom));
      if (!pend_i && !pend_d) set_i($urandom & 32'hFFFF_FFFE);
      txn($urandom_range(3), $urandom, ($urandom_range(3) == 0));
    end
    while (pend_i || pend_d) txn(0, $urandom, 0);

    // Timeout: err[0] rises after Tmo silent grant cycles; the late response still completes.
    set_i(32'h8000_0100);
    txn(10, 32'hCAFE_F00D, 0);
    set_d(32'h8000_2003, 32'h0, 4'b0000, 1'b0);
    txn(1, 32'h0BAD_CAFE, 0);

    // Spurious response in idle: no strobe, err[1] sets.
    bus.m_resp_valid = 1'b1;
    bus.m_rdata      = 32'hFFFF_FFFF;
    #1;
    chk("spur_strobes", 64'({bus.i_rdata_valid, bus.d_rdata_valid}), 64'(0));
    @(posedge clk);
    #2 bus.m_resp_valid = 1'b0;
    exp_err[1] = 1'b1;
    #1;
    chk("spur_err", 64'(bus.err), 64'(exp_err));

    // Reset in the middle of a grant.
    set_i(32'h8000_0200);
    drive_reqs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_grant", 64'(bus.m_valid), 64'(1));
    @(posedge clk);
    #2;
    pend_i = 0;
    drive_reqs();
    rst     = 1'b0;
    exp_err = 2'b00;
    #1;
    chk("midrst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("midrst_err", 64'(bus.err), 64'(0));

    // The response to the aborted transaction now arrives in idle.
    bus.m_resp_valid = 1'b1;
    #1;
    chk("late_strobes", 64'({bus.i_rdata_valid, bus.d_rdata_valid}), 64'(0));
    @(posedge clk);
    #2 bus.m_resp_valid = 1'b0;
    #1;
    chk("late_err", 64'(bus.err), 64'(2'b10));
    chk("late_m_valid", 64'(bus.m_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
